// File: rtl/hamming_pkg.sv
// Shared constants and helpers for the (12,8) Hamming encoder/decoder pair.
// Bit i of a codeword holds Hamming position i+1; parity sits at the
// power-of-two positions, data fills the remaining ones in ascending order.
package hamming_pkg;

  localparam int CODE_W = 12;
  localparam int DATA_W = 8;
  localparam int SYN_W  = 4;
  localparam int PAR_W  = 4;

  typedef logic [CODE_W-1:0] code_t;
  typedef logic [DATA_W-1:0] data_t;
  typedef logic [SYN_W-1:0]  syn_t;

  // Zero-based code bit indices of the parity bits p1, p2, p4, p8.
  localparam int PAR_POS [PAR_W] = '{0, 1, 3, 7};

  // Zero-based code bit index carrying data bit d0..d7.
  localparam int DATA_POS [DATA_W] = '{2, 4, 5, 6, 8, 9, 10, 11};

  // Code bits covered by each syndrome bit (s0 checks positions with bit 0 set, etc.).
  localparam code_t SYN_MASK [SYN_W] = '{12'h555, 12'h666, 12'h878, 12'hF80};

  // Highest syndrome that still names a real code position.
  localparam syn_t SYN_MAX_CORR = 4'd12;

  // Outcome of inspecting one syndrome.
  typedef enum logic [1:0] {
    ERR_NONE   = 2'd0,
    ERR_CORR   = 2'd1,
    ERR_UNCORR = 2'd2
  } err_kind_t;

  // Pull the eight message bits out of a codeword.
  function automatic data_t extract_data(input code_t c);
    data_t d;
    for (int i = 0; i < DATA_W; i++) begin
      d[i] = c[DATA_POS[i]];
    end
    return d;
  endfunction

  // Zero means clean, 1..12 points at a fixable bit, 13..15 cannot be located.
  function automatic err_kind_t classify(input syn_t s);
    err_kind_t k;
    if (s == '0) begin
      k = ERR_NONE;
    end else if (s <= SYN_MAX_CORR) begin
      k = ERR_CORR;
    end else begin
      k = ERR_UNCORR;
    end
    return k;
  endfunction

endpackage

// File: rtl/hamming_syndrome.sv
// Purely combinational syndrome generator: each syndrome bit is the parity
// of the code bits it covers.
module hamming_syndrome
  import hamming_pkg::*;
(
  input  logic [CODE_W-1:0] code,
  output logic [SYN_W-1:0]  syn
);

  generate
    for (genvar gi = 0; gi < SYN_W; gi++) begin : g_syn
      assign syn[gi] = ^(code & SYN_MASK[gi]);
    end
  endgenerate

endmodule

// File: rtl/hamming_dec.sv
// Two-stage (12,8) Hamming decoder with single-error correction, an
// uncorrectable-syndrome flag and saturating error-event counters.
// Stage 1 latches the codeword with its syndrome; stage 2 latches the
// corrected data and flags. Double errors that alias to 1..12 are
// miscorrected by design of the code.
module hamming_dec
  import hamming_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [CODE_W-1:0] code_in,
  input  logic              in_valid,
  input  logic              cnt_clr,
  output logic [DATA_W-1:0] data_out,
  output logic              out_valid,
  output logic [SYN_W-1:0]  syndrome,
  output logic              err_corr,
  output logic              err_uncorr,
  output logic [CNT_W-1:0]  corr_cnt,
  output logic [CNT_W-1:0]  uncorr_cnt
);

  // ---------------------------------------------------------------- stage 1
  syn_t  syn_comb;
  code_t s1_code_reg;
  syn_t  s1_syn_reg;
  logic  s1_valid_reg;

  hamming_syndrome u_syndrome (
    .code (code_in),
    .syn  (syn_comb)
  );

  // Stage 1 register: codeword, its syndrome and the valid marker.
  always_ff @(posedge clk) begin
    if (!rst) begin
      s1_code_reg  <= '0;
      s1_syn_reg   <= '0;
      s1_valid_reg <= 1'b0;
    end else begin
      s1_valid_reg <= in_valid;
      if (in_valid) begin
        s1_code_reg <= code_in;
        s1_syn_reg  <= syn_comb;
      end
    end
  end

  // ------------------------------------------------------ correction logic
  err_kind_t s1_kind;
  code_t     flip_mask;

  assign s1_kind = classify(s1_syn_reg);

  // Exactly one bit is flipped, and only when the syndrome names a position.
  generate
    for (genvar gi = 0; gi < CODE_W; gi++) begin : g_flip
      assign flip_mask[gi] = (s1_kind == ERR_CORR) && (s1_syn_reg == syn_t'(gi + 1));
    end
  endgenerate

  // ---------------------------------------------------------------- stage 2
  data_t data_reg, data_next;
  syn_t  syn_reg, syn_next;
  logic  valid_reg, valid_next;
  logic  corr_reg, corr_next;
  logic  uncorr_reg, uncorr_next;

  // Next-state for stage 2: data/syndrome hold when idle, flags only pulse with valid.
  always_comb begin
    data_next   = data_reg;
    syn_next    = syn_reg;
    valid_next  = s1_valid_reg;
    corr_next   = 1'b0;
    uncorr_next = 1'b0;
    if (s1_valid_reg) begin
      data_next   = extract_data(s1_code_reg ^ flip_mask);
      syn_next    = s1_syn_reg;
      corr_next   = (s1_kind == ERR_CORR);
      uncorr_next = (s1_kind == ERR_UNCORR);
    end
  end

  // Stage 2 register: everything the consumer sees.
  always_ff @(posedge clk) begin
    if (!rst) begin
      data_reg   <= '0;
      syn_reg    <= '0;
      valid_reg  <= 1'b0;
      corr_reg   <= 1'b0;
      uncorr_reg <= 1'b0;
    end else begin
      data_reg   <= data_next;
      syn_reg    <= syn_next;
      valid_reg  <= valid_next;
      corr_reg   <= corr_next;
      uncorr_reg <= uncorr_next;
    end
  end

  // ---------------------------------------------------------------- counters
  // Index 0 counts corrected events, index 1 uncorrectable ones. Counting on
  // the stage-2 load edge keeps each count in step with its visible flag.
  logic [1:0]            cnt_evt;
  logic [CNT_W-1:0]      cnt_reg  [2];
  logic [CNT_W-1:0]      cnt_next [2];

  assign cnt_evt = {uncorr_next, corr_next};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
      // Clear wins over a same-cycle event; otherwise count up and stick at all-ones.
      always_comb begin
        cnt_next[gi] = cnt_reg[gi];
        if (cnt_clr) begin
          cnt_next[gi] = '0;
        end else if (cnt_evt[gi] && !(&cnt_reg[gi])) begin
          cnt_next[gi] = cnt_reg[gi] + CNT_W'(1);
        end
      end

      // Counter register.
      always_ff @(posedge clk) begin
        if (!rst) begin
          cnt_reg[gi] <= '0;
        end else begin
          cnt_reg[gi] <= cnt_next[gi];
        end
      end
    end
  endgenerate

  // ----------------------------------------------------------------- outputs
  assign data_out   = data_reg;
  assign syndrome   = syn_reg;
  assign out_valid  = valid_reg;
  assign err_corr   = corr_reg;
  assign err_uncorr = uncorr_reg;
  assign corr_cnt   = cnt_reg[0];
  assign uncorr_cnt = cnt_reg[1];

endmodule

// File: tb/tb_hamming_dec.sv
// Scoreboard bench for hamming_dec: stimulus pushes expected results from a
// position-XOR Hamming model; a monitor pops and compares each output cycle.
module tb_hamming_dec;

  localparam int CW     = 2;
  localparam int CNTMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [11:0]   code_in = '0;
  logic          in_valid = 1'b0;
  logic          cnt_clr = 1'b0;
  logic [7:0]    data_out;
  logic          out_valid;
  logic [3:0]    syndrome;
  logic          err_corr;
  logic          err_uncorr;
  logic [CW-1:0] corr_cnt;
  logic [CW-1:0] uncorr_cnt;

  hamming_dec #(.CNT_W(CW)) dut (
    .clk        (clk),
    .rst        (rst),
    .code_in    (code_in),
    .in_valid   (in_valid),
    .cnt_clr    (cnt_clr),
    .data_out   (data_out),
    .out_valid  (out_valid),
    .syndrome   (syndrome),
    .err_corr   (err_corr),
    .err_uncorr (err_uncorr),
    .corr_cnt   (corr_cnt),
    .uncorr_cnt (uncorr_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [11:0] code;
    logic [7:0]  data;
    logic [3:0]  syn;
    logic        corr;
    logic        uncorr;
    int          due;
  } exp_t;

  exp_t sbq[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc    = 0;

  // Build a valid codeword: data in non-power-of-two positions, parity chosen
  // so the XOR of all set positions is zero.
  function automatic logic [11:0] encode(input logic [7:0] d);
    logic [11:0] c;
    int k;
    int x;
    c = '0;
    k = 0;
    x = 0;
    for (int p = 1; p <= 12; p++) begin
      if ((p & (p - 1)) != 0) begin
        c[p-1] = d[k];
        k++;
      end
    end
    for (int p = 1; p <= 12; p++) if (c[p-1]) x = x ^ p;
    for (int j = 0; j < 4; j++) if (x[j]) c[(1 << j) - 1] = 1'b1;
    return c;
  endfunction

  // Reference decode: syndrome is the XOR of positions of all set bits.
  function automatic exp_t model(input logic [11:0] c);
    exp_t e;
    int s;
    int k;
    logic [11:0] w;
    s = 0;
    k = 0;
    w = c;
    for (int p = 1; p <= 12; p++) if (c[p-1]) s = s ^ p;
    e.code   = c;
    e.syn    = 4'(s);
    e.corr   = (s >= 1) && (s <= 12);
    e.uncorr = (s >= 13);
    if (e.corr) w[s-1] = ~w[s-1];
    e.data = '0;
    for (int p = 1; p <= 12; p++) begin
      if ((p & (p - 1)) != 0) begin
        e.data[k] = w[p-1];
        k++;
      end
    end
    e.due = 0;
    return e;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=0x%0h expected=0x%0h", name, cyc, act, exp);
    end
  endtask

  // One input cycle, applied on the falling edge and sampled on the next rise.
  task automatic drive(input bit v, input logic [11:0] c, input bit clr, input bit r);
    exp_t e;
    @(negedge clk);
    in_valid = v;
    code_in  = c;
    cnt_clr  = clr;
    rst      = r;
    if (v && r) begin
      e = model(c);
      e.due = cyc + 2;
      sbq.push_back(e);
    end
  endtask

  function automatic logic [11:0] flip_bits(input logic [11:0] c, input int n);
    logic [11:0] w;
    int a;
    int b;
    w = c;
    a = $urandom_range(0, 11);
    if (n >= 1) w[a] = ~w[a];
    if (n >= 2) begin
      b = $urandom_range(0, 10);
      if (b >= a) b++;
      w[b] = ~w[b];
    end
    return w;
  endfunction

  // Monitor: sample 1 time unit after each rising edge.
  initial begin
    exp_t        e;
    logic [7:0]  last_d;
    logic [3:0]  last_s;
    int          cc;
    int          uc;
    bit          exp_valid;
    last_d = '0;
    last_s = '0;
    cc = 0;
    uc = 0;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      while (sbq.size() > 0 && sbq[0].due < cyc) void'(sbq.pop_front());
      if (!rst) begin
        sbq.delete();
        cc = 0;
        uc = 0;
        last_d = '0;
        last_s = '0;
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_data_out", int'(data_out), 0);
        chk("rst_syndrome", int'(syndrome), 0);
        chk("rst_err_corr", int'(err_corr), 0);
        chk("rst_err_uncorr", int'(err_uncorr), 0);
        chk("rst_corr_cnt", int'(corr_cnt), 0);
        chk("rst_uncorr_cnt", int'(uncorr_cnt), 0);
      end else begin
        exp_valid = (sbq.size() > 0) && (sbq[0].due == cyc);
        chk("out_valid", int'(out_valid), int'(exp_valid));
        if (exp_valid) begin
          e = sbq.pop_front();
          chk("data_out", int'(data_out), int'(e.data));
          chk("syndrome", int'(syndrome), int'(e.syn));
          chk("err_corr", int'(err_corr), int'(e.corr));
          chk("err_uncorr", int'(err_uncorr), int'(e.uncorr));
          last_d = e.data;
          last_s = e.syn;
          $display("cyc %0d code=%03h data=%02h syn=%0d corr=%0b uncorr=%0b cnt=%0d/%0d",
                   cyc, e.code, data_out, syndrome, err_corr, err_uncorr, corr_cnt, uncorr_cnt);
        end else begin
          chk("idle_err_corr", int'(err_corr), 0);
          chk("idle_err_uncorr", int'(err_uncorr), 0);
          chk("hold_data_out", int'(data_out), int'(last_d));
          chk("hold_syndrome", int'(syndrome), int'(last_s));
        end
        if (cnt_clr) begin
          cc = 0;
          uc = 0;
        end else if (exp_valid) begin
          if (e.corr && cc < CNTMAX) cc++;
          if (e.uncorr && uc < CNTMAX) uc++;
        end
        chk("corr_cnt", int'(corr_cnt), cc);
        chk("uncorr_cnt", int'(uncorr_cnt), uc);
      end
    end
  end

  // Stimulus.
  initial begin
    logic [11:0] c;
    int          n;
    bit          r;
    // Reset for three edges.
    repeat (3) drive(1'b0, 12'h000, 1'b0, 1'b0);
    // Directed words: clean, data error, parity error, uncorrectable.
    drive(1'b1, 12'hA27, 1'b0, 1'b1);
    drive(1'b1, 12'hA07, 1'b0, 1'b1);
    drive(1'b1, 12'hA26, 1'b0, 1'b1);
    drive(1'b1, 12'h226, 1'b0, 1'b1);
    repeat (3) drive(1'b0, 12'h000, 1'b0, 1'b1);
    // Clear, then five corrected words back-to-back to push corr_cnt into saturation.
    drive(1'b0, 12'h000, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) drive(1'b1, flip_bits(encode(8'($urandom)), 1), 1'b0, 1'b1);
    repeat (3) drive(1'b0, 12'h000, 1'b0, 1'b1);
    // Clear landing on the same edge as a corrected word reaching stage 2.
    drive(1'b1, 12'hA07, 1'b0, 1'b1);
    drive(1'b0, 12'h000, 1'b1, 1'b1);
    repeat (3) drive(1'b0, 12'h000, 1'b0, 1'b1);
    // Five back-to-back words with alternating errors, then a one-cycle reset mid-stream.
    for (int i = 0; i < 5; i++) begin
      c = encode(8'($urandom));
      if (i % 2 == 1) c = flip_bits(c, 1);
      drive(1'b1, c, 1'b0, 1'b1);
    end
    drive(1'b1, 12'hA07, 1'b0, 1'b0);
    drive(1'b1, 12'hA27, 1'b0, 1'b1);
    repeat (3) drive(1'b0, 12'h000, 1'b0, 1'b1);
    // Randomised traffic: gaps, 0/1/2-bit errors, occasional clears and resets.
    for (int i = 0; i < 1500; i++) begin
      n = $urandom_range(0, 3);
      if (n == 3) n = 1;
      c = flip_bits(encode(8'($urandom)), n);
      r = ($urandom_range(0, 149) != 0);
      drive($urandom_range(0, 3) != 0, c, $urandom_range(0, 39) == 0, r);
    end
    // Drain with a bounded idle period.
    repeat (6) drive(1'b0, 12'h000, 1'b0, 1'b1);
    chk("scoreboard_drained", sbq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
